// File: rtl/mac_result_drain.sv
// -----------------------------------------------------------------------------
// mac_result_drain
//   Reads out the MAC array accumulators. When start is accepted, the block
//   copies all MAC_WIDTH x MAC_WIDTH accumulators and shift_amt into a local
//   buffer and pulses clear_acc, so the array can begin its next tile at once.
//   It then streams the requantized results in row-major order over a
//   valid/ready port. Requantization is an arithmetic right shift followed by
//   signed saturation to OUT_WIDTH bits.
//
// Ports
//   clk, rst           single rising-edge clock, async active-high reset
//   start              snapshot+drain request, honoured only in IDLE
//   shift_amt          right-shift amount, captured with the accepted start
//   c_acc_flat         C[i,j] at bits [(i*N+j)*ACC_WIDTH +: ACC_WIDTH]
//   clear_acc          one-cycle pulse to the array, the cycle after start
//   busy               frame in progress (STREAM state)
//   out_valid/ready    output handshake
//   out_data/row/col   requantized element and its coordinates
//   out_sat            element was saturated
//   out_last           element is C[N-1,N-1]
//   done               one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module mac_result_drain #(
   parameter int MAC_WIDTH = 8,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT_W   = 5,
   localparam int IDX_W    = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [SHIFT_W-1:0]                     shift_amt,
   input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] c_acc_flat,
   output logic                                   clear_acc,
   output logic                                   busy,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [OUT_WIDTH-1:0]                   out_data,
   output logic [IDX_W-1:0]                       out_row,
   output logic [IDX_W-1:0]                       out_col,
   output logic                                   out_sat,
   output logic                                   out_last,
   output logic                                   done
);

   localparam int NUM_EL = MAC_WIDTH * MAC_WIDTH;
   localparam int FLAT_W = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAC_WIDTH - 1);

   // Saturation bounds expressed at accumulator width for a signed compare.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [OUT_WIDTH-1:0]        OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]        OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              row_q, row_d;
   logic [IDX_W-1:0]              col_q, col_d;
   logic [SHIFT_W-1:0]            shift_q;
   logic                          clear_acc_q;
   logic signed [ACC_WIDTH-1:0]   snap_q [NUM_EL];

   logic                          load;
   logic                          last_beat;
   logic [FLAT_W-1:0]             flat_idx;
   logic signed [ACC_WIDTH-1:0]   acc_sel;
   logic signed [ACC_WIDTH-1:0]   shifted;
   logic [OUT_WIDTH-1:0]          q_data;
   logic                          q_sat;

   assign last_beat = (row_q == IDX_MAX) && (col_q == IDX_MAX);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      load    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STREAM;
               load    = 1'b1;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_STREAM: begin
            // In STREAM out_valid is high, so out_ready alone means a transfer.
            if (out_ready) begin
               if (last_beat) begin
                  state_d = ST_DONE;
                  row_d   = '0;
                  col_d   = '0;
               end else if (col_q == IDX_MAX) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, index and snapshot registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         shift_q     <= '0;
         clear_acc_q <= 1'b0;
         // NOTE: the snapshot buffer is reset on purpose so that no stale
         // frame data is observable after reset; it is small enough to be flops.
         for (int k = 0; k < NUM_EL; k++) begin
            snap_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         clear_acc_q <= load;
         if (load) begin
            shift_q <= shift_amt;
            for (int k = 0; k < NUM_EL; k++) begin
               snap_q[k] <= c_acc_flat[k*ACC_WIDTH +: ACC_WIDTH];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Requantize the element at the current index (no added latency)
   // ---------------------------------------------------------------------------
   always_comb begin
      flat_idx = FLAT_W'(int'(row_q) * MAC_WIDTH + int'(col_q));
      acc_sel  = snap_q[flat_idx];

      // Shifts at or beyond the accumulator width collapse to pure sign fill.
      if (32'(shift_q) >= 32'(ACC_WIDTH)) begin
         shifted = {ACC_WIDTH{acc_sel[ACC_WIDTH-1]}};
      end else begin
         shifted = acc_sel >>> shift_q;
      end

      q_sat  = 1'b1;
      q_data = shifted[OUT_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         q_data = OUT_MAX;
      end else if (shifted < SAT_MIN) begin
         q_data = OUT_MIN;
      end else begin
         q_sat = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs; beat fields are zero whenever no beat is offered
   // ---------------------------------------------------------------------------
   assign out_valid = (state_q == ST_STREAM);
   assign busy      = (state_q == ST_STREAM);
   assign done      = (state_q == ST_DONE);
   assign clear_acc = clear_acc_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_data  = out_valid ? q_data : '0;
   assign out_sat   = out_valid & q_sat;
   assign out_last  = out_valid & last_beat;

endmodule
